spm_mem_arbiter: RTL
====================

Name: spm_mem_arbiter

Overview:
- Two-port arbiter that shares the single-port program/data memory of the RISC_SPM system between two requesters.
- Port 0 is the RISC_SPM processor bus. Port 1 is a loader/debug master that preloads programs and inspects memory while the processor runs.
- Uses round-robin arbitration with bounded bursts. Drives the memory bus (address, write data, write strobe) and returns synchronous read data.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_BURST, 4, maximum consecutive beats one port may take while the other port is requesting (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- p0_req  in  1  port 0 beat request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 owns memory this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DW  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data, valid 1 cycle after the address.
- owner  out  1  index of the last/current granted port.

Behaviour:
- Clocking: one clock (clk). Reset rst is synchronous, active-high. All state changes on the rising edge of clk.
- FSM states:
  - IDLE: no grant.
  - OWN0: p0 owns memory.
  - OWN1: p1 owns memory.
- Grants are registered: pX_gnt = (state==OWNx).
- Beat definition: a beat on port X occurs in any cycle where pX_req && pX_gnt.
- Memory mux:
  - mem_addr/mem_wdata = owner port inputs when a grant is active; otherwise held at the last-driven value.
  - mem_we = pX_gnt & pX_req & pX_we. It is never 1 without a beat.
- Read return:
  - A read beat on port X sets pX_rvalid=1 for exactly the next cycle.
  - pX_rdata = mem_rdata (pass-through). It is meaningful only while pX_rvalid=1.
  - Back-to-back read beats give back-to-back rvalid.
- Latency: req rising in cycle N (from IDLE) gives gnt=1 and the first beat in cycle N+1.
- IDLE transitions:
  - Both ports requesting: go to OWN of the port ≠ last_owner.
  - One port requesting: go to that port's OWN state.
  - Neither requesting: stay in IDLE.
- OWNx transitions (evaluated each edge):
  - pX_req=0 and other port requesting: go to OWN_other.
  - pX_req=0 and other port not requesting: go to IDLE.
  - Beat this cycle, beat_cnt==MAX_BURST-1, and other port requesting: go to OWN_other.
  - Otherwise: stay in OWNx.
- beat_cnt:
  - Width $clog2(MAX_BURST+1).
  - Increments on each beat; saturates while the other port is idle.
  - Clears on any state change.
- Switch timing: handover between ports has zero bubble cycles. The new owner's gnt is high in the cycle right after the old owner's last beat.
- A sole requester keeps its grant indefinitely; MAX_BURST applies only under contention.
- MAX_BURST=1 gives strict alternation under contention.
- last_owner is updated on each entry to OWNx; owner = last_owner.
- Reset values:
  - state=IDLE, last_owner=1 (so p0 wins the first tie), beat_cnt=0.
  - p0_gnt=p1_gnt=0, p0_rvalid=p1_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=1.
- Reset mid-burst: the next cycle is fully in reset state. Any pending rvalid is dropped, and a read issued in the reset cycle returns nothing.
- Requester inputs may change only while the port has no beat pending. The arbiter does not buffer requests.

Test Plan:
- Reset: rst=1 for 2 cycles with both req=1 → both gnt=0, both rvalid=0, mem_we=0, owner=1. Release → p0_gnt=1 the next cycle.
- Single write: p1_req=1, p1_we=1, p1_addr=0x10, p1_wdata=0xA5 at cycle N → p1_gnt=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 at N+1. Drop req → IDLE, gnt=0 at N+3.
- Read return: memory preloaded [0x20]=0x3C; p0 reads 0x20 → p0_rvalid=1, p0_rdata=0x3C exactly one cycle after the beat; p1_rvalid stays 0.
- Contention: both req held, MAX_BURST=4 → grant sequence p0×4, p1×4, p0×4, with no idle cycles and p1_gnt asserted the cycle after p0's 4th beat.
- Sole requester: p0_req held 10 cycles, p1 idle → p0_gnt high for 10 consecutive cycles. Drop p0_req → p0_gnt falls one cycle later.
- Mid-burst reset: rst asserted during an OWN1 read beat → next cycle p1_gnt=0, p1_rvalid=0. Both req after release → p0 granted first.

Source files
------------

// File: rtl/spm_mem_arbiter.sv
// spm_mem_arbiter: shares the RISC_SPM single-port program/data memory
// between the processor bus (port 0) and a loader/debug master (port 1).
// Round-robin arbitration with bounded bursts under contention, registered
// grants, pass-through read data with a one-cycle rvalid strobe.
//
// Handshake: a requester raises pX_req with pX_we/pX_addr/pX_wdata stable;
// a beat happens in every cycle where pX_req && pX_gnt are both high. The
// arbiter does not buffer requests, so a requester must hold its inputs
// until it sees the beat. A read beat is answered by pX_rvalid in the next
// cycle, with pX_rdata valid only while pX_rvalid is high.
module spm_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]   addr_hold_q, addr_hold_d;
  logic [DW-1:0]   wdata_hold_q, wdata_hold_d;
  logic            p0_rvalid_q, p1_rvalid_q;
  logic            beat0, beat1, burst_done;

  assign p0_gnt      = (state_q == OWN0);
  assign p1_gnt      = (state_q == OWN1);
  assign beat0       = p0_req & p0_gnt;
  assign beat1       = p1_req & p1_gnt;
  // The beat that finds the counter at MAX_BURST-1 is the last one allowed
  // while the other port waits.
  assign burst_done  = (beat_cnt_q == CW'(MAX_BURST - 1));
  assign owner       = last_owner_q;
  assign dbg_state_o = state_q;

  assign mem_we      = (beat0 & p0_we) | (beat1 & p1_we);
  assign p0_rvalid   = p0_rvalid_q;
  assign p1_rvalid   = p1_rvalid_q;
  assign p0_rdata    = mem_rdata;
  assign p1_rdata    = mem_rdata;

  // Next-state, burst counter and last-owner tracking.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req && p1_req) state_d = last_owner_q ? OWN0 : OWN1;
        else if (p0_req)      state_d = OWN0;
        else if (p1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!p0_req)                    state_d = p1_req ? OWN1 : IDLE;
        else if (burst_done && p1_req)  state_d = OWN1;
      end
      OWN1: begin
        if (!p1_req)                    state_d = p0_req ? OWN0 : IDLE;
        else if (burst_done && p0_req)  state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    // Counter saturates at MAX_BURST-1 so a late-arriving competitor takes
    // over after the sole owner's very next beat.
    if (state_d != state_q)               beat_cnt_d = '0;
    else if ((beat0 || beat1) && !burst_done) beat_cnt_d = beat_cnt_q + CW'(1);
    if (state_d == OWN0 && state_q != OWN0) last_owner_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_owner_d = 1'b1;
  end

  // Memory bus mux: follow the owner while granted, otherwise hold.
  always_comb begin
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    if (p0_gnt) begin
      addr_hold_d  = p0_addr;
      wdata_hold_d = p0_wdata;
    end else if (p1_gnt) begin
      addr_hold_d  = p1_addr;
      wdata_hold_d = p1_wdata;
    end
    mem_addr  = addr_hold_d;
    mem_wdata = wdata_hold_d;
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
      p0_rvalid_q  <= beat0 & ~p0_we;
      p1_rvalid_q  <= beat1 & ~p1_we;
    end
  end

endmodule
